// File: rtl/buyruk_onbellegi_pkg.sv
// Shared definitions for the instruction cache: widths, address-field helpers
// and the controller state encoding.
package buyruk_onbellegi_pkg;

    localparam int BUYRUK_GENISLIK     = 32;
    localparam int ADRES_GENISLIK      = 32;
    localparam int BAYT_GENISLIK       = 2;
    localparam int VARSAYILAN_SATIR    = 64;
    localparam int VARSAYILAN_KELIME   = 4;

    // Address field widths derived from the geometry parameters.
    function automatic int ofset_genislik(input int satir_kelime);
        return $clog2(satir_kelime);
    endfunction

    function automatic int indeks_genislik(input int satir_sayisi);
        return $clog2(satir_sayisi);
    endfunction

    function automatic int etiket_genislik(input int satir_sayisi, input int satir_kelime);
        return ADRES_GENISLIK - BAYT_GENISLIK - $clog2(satir_kelime) - $clog2(satir_sayisi);
    endfunction

    typedef enum logic [1:0] {
        BOS    = 2'd0,
        ISTEK  = 2'd1,
        DOLDUR = 2'd2,
        CEVAP  = 2'd3
    } durum_t;

endpackage

// File: rtl/onbellek_dizisi.sv
// Tag and data storage of the instruction cache: one synchronous write port
// used by the refill, one asynchronous read port used by the lookup.
module onbellek_dizisi
    import buyruk_onbellegi_pkg::*;
#(
    parameter int SATIR_SAYISI = VARSAYILAN_SATIR,
    parameter int SATIR_KELIME = VARSAYILAN_KELIME,
    parameter int INDEKS_G     = indeks_genislik(VARSAYILAN_SATIR),
    parameter int OFSET_G      = ofset_genislik(VARSAYILAN_KELIME),
    parameter int ETIKET_G     = etiket_genislik(VARSAYILAN_SATIR, VARSAYILAN_KELIME)
) (
    input  logic                       clk_i,
    input  logic                       yaz_veri,
    input  logic                       yaz_etiket,
    input  logic [INDEKS_G-1:0]        yaz_indeks,
    input  logic [OFSET_G-1:0]         yaz_ofset,
    input  logic [BUYRUK_GENISLIK-1:0] yaz_kelime,
    input  logic [ETIKET_G-1:0]        yaz_etiket_degeri,
    input  logic [INDEKS_G-1:0]        oku_indeks,
    input  logic [OFSET_G-1:0]         oku_ofset,
    output logic [ETIKET_G-1:0]        okunan_etiket,
    output logic [BUYRUK_GENISLIK-1:0] okunan_kelime
);

    logic [BUYRUK_GENISLIK-1:0] veri_dizisi   [SATIR_SAYISI*SATIR_KELIME];
    logic [ETIKET_G-1:0]        etiket_dizisi [SATIR_SAYISI];

    // Refill writes one word per beat and the tag on the last beat.
    // NOTE: storage arrays have no reset; line validity is tracked by separate flops, so stale contents are never used.
    always_ff @(posedge clk_i) begin
        if (yaz_veri) begin
            veri_dizisi[{yaz_indeks, yaz_ofset}] <= yaz_kelime;
        end
        if (yaz_etiket) begin
            etiket_dizisi[yaz_indeks] <= yaz_etiket_degeri;
        end
    end

    assign okunan_etiket = etiket_dizisi[oku_indeks];
    assign okunan_kelime = veri_dizisi[{oku_indeks, oku_ofset}];

endmodule

// File: rtl/buyruk_onbellegi.sv
// Direct-mapped instruction cache: one-cycle hits, fixed-length burst refill
// on a miss, redirect cancellation and whole-cache invalidation.
module buyruk_onbellegi
    import buyruk_onbellegi_pkg::*;
#(
    parameter int SATIR_SAYISI = VARSAYILAN_SATIR,
    parameter int SATIR_KELIME = VARSAYILAN_KELIME
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        getir_istek_i,
    input  logic [31:0] getir_adres_i,
    output logic        getir_hazir_o,
    input  logic        getir_iptal_i,
    output logic        getir_gecerli_o,
    output logic [31:0] getir_buyruk_o,
    input  logic        temizle_i,
    output logic        bellek_istek_o,
    output logic [31:0] bellek_adres_o,
    input  logic        bellek_hazir_i,
    input  logic        bellek_gecerli_i,
    input  logic [31:0] bellek_veri_i
);

    localparam int OFSET_G  = ofset_genislik(SATIR_KELIME);
    localparam int INDEKS_G = indeks_genislik(SATIR_SAYISI);
    localparam int ETIKET_G = etiket_genislik(SATIR_SAYISI, SATIR_KELIME);
    localparam logic [OFSET_G-1:0] SON_KELIME = OFSET_G'(SATIR_KELIME - 1);

    durum_t                     durum;
    logic [SATIR_SAYISI-1:0]    gecerli_bitleri;
    logic [ETIKET_G-1:0]        etiket_r;
    logic [INDEKS_G-1:0]        indeks_r;
    logic [OFSET_G-1:0]         ofset_r;
    logic [OFSET_G-1:0]         sayac;
    logic                       iptal;
    logic                       temizlendi;
    logic [BUYRUK_GENISLIK-1:0] cevap_kelime;

    logic [OFSET_G-1:0]         istek_ofset;
    logic [INDEKS_G-1:0]        istek_indeks;
    logic [ETIKET_G-1:0]        istek_etiket;
    logic [ETIKET_G-1:0]        okunan_etiket;
    logic [BUYRUK_GENISLIK-1:0] okunan_kelime;
    logic                       kabul;
    logic                       isabet;
    logic                       vurus;
    logic                       son_vurus;
    logic                       unused_bayt;

    assign istek_ofset  = getir_adres_i[OFSET_G+1:2];
    assign istek_indeks = getir_adres_i[OFSET_G+INDEKS_G+1:OFSET_G+2];
    assign istek_etiket = getir_adres_i[31:OFSET_G+INDEKS_G+2];
    assign unused_bayt  = ^getir_adres_i[1:0];

    // A same-cycle invalidate hides every line from the lookup.
    assign kabul     = getir_istek_i && getir_hazir_o;
    assign isabet    = gecerli_bitleri[istek_indeks] && !temizle_i && (okunan_etiket == istek_etiket);
    assign vurus     = (durum == DOLDUR) && bellek_gecerli_i;
    assign son_vurus = vurus && (sayac == SON_KELIME);

    onbellek_dizisi #(
        .SATIR_SAYISI (SATIR_SAYISI),
        .SATIR_KELIME (SATIR_KELIME),
        .INDEKS_G     (INDEKS_G),
        .OFSET_G      (OFSET_G),
        .ETIKET_G     (ETIKET_G)
    ) u_dizi (
        .clk_i             (clk_i),
        .yaz_veri          (vurus),
        .yaz_etiket        (son_vurus),
        .yaz_indeks        (indeks_r),
        .yaz_ofset         (sayac),
        .yaz_kelime        (bellek_veri_i),
        .yaz_etiket_degeri (etiket_r),
        .oku_indeks        (istek_indeks),
        .oku_ofset         (istek_ofset),
        .okunan_etiket     (okunan_etiket),
        .okunan_kelime     (okunan_kelime)
    );

    // Valid flops: invalidate wins over the line completed in the same cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gecerli_bitleri <= '0;
        end else if (temizle_i) begin
            gecerli_bitleri <= '0;
        end else if (son_vurus && !temizlendi) begin
            gecerli_bitleri[indeks_r] <= 1'b1;
        end
    end

    // Controller FSM with registered handshake and response outputs.
    // NOTE: every state flop here uses <= so all updates see pre-edge values, matching the hardware.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum           <= BOS;
            getir_hazir_o   <= 1'b1;
            getir_gecerli_o <= 1'b0;
            getir_buyruk_o  <= '0;
            bellek_istek_o  <= 1'b0;
            bellek_adres_o  <= '0;
            etiket_r        <= '0;
            indeks_r        <= '0;
            ofset_r         <= '0;
            sayac           <= '0;
            iptal           <= 1'b0;
            temizlendi      <= 1'b0;
            cevap_kelime    <= '0;
        end else begin
            getir_gecerli_o <= 1'b0;
            if ((durum == ISTEK) || (durum == DOLDUR)) begin
                if (getir_iptal_i) iptal      <= 1'b1;
                if (temizle_i)     temizlendi <= 1'b1;
            end
            case (durum)
                BOS: begin
                    if (kabul) begin
                        etiket_r <= istek_etiket;
                        indeks_r <= istek_indeks;
                        ofset_r  <= istek_ofset;
                        if (isabet) begin
                            getir_gecerli_o <= !getir_iptal_i;
                            getir_buyruk_o  <= okunan_kelime;
                        end else begin
                            durum          <= ISTEK;
                            getir_hazir_o  <= 1'b0;
                            bellek_istek_o <= 1'b1;
                            bellek_adres_o <= {istek_etiket, istek_indeks, {(OFSET_G+2){1'b0}}};
                            sayac          <= '0;
                            iptal          <= 1'b0;
                            temizlendi     <= 1'b0;
                        end
                    end
                end
                ISTEK: begin
                    if (bellek_hazir_i) begin
                        bellek_istek_o <= 1'b0;
                        durum          <= DOLDUR;
                    end
                end
                DOLDUR: begin
                    if (bellek_gecerli_i) begin
                        sayac <= sayac + OFSET_G'(1);
                        if (sayac == ofset_r) cevap_kelime <= bellek_veri_i;
                        if (sayac == SON_KELIME) begin
                            durum           <= CEVAP;
                            getir_gecerli_o <= !(iptal || getir_iptal_i);
                            getir_buyruk_o  <= (sayac == ofset_r) ? bellek_veri_i : cevap_kelime;
                        end
                    end
                end
                CEVAP: begin
                    durum         <= BOS;
                    getir_hazir_o <= 1'b1;
                end
                default: begin
                    durum <= BOS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buyruk_onbellegi.sv
// Directed self-checking bench for the instruction cache at default geometry
// (64 lines x 4 words): offset = a[3:2], index = a[9:4], tag = a[31:10].
module tb_buyruk_onbellegi;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        getir_istek_i;
    logic [31:0] getir_adres_i;
    logic        getir_hazir_o;
    logic        getir_iptal_i;
    logic        getir_gecerli_o;
    logic [31:0] getir_buyruk_o;
    logic        temizle_i;
    logic        bellek_istek_o;
    logic [31:0] bellek_adres_o;
    logic        bellek_hazir_i;
    logic        bellek_gecerli_i;
    logic [31:0] bellek_veri_i;

    int compared   = 0;
    int mismatched = 0;

    buyruk_onbellegi dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .getir_istek_i    (getir_istek_i),
        .getir_adres_i    (getir_adres_i),
        .getir_hazir_o    (getir_hazir_o),
        .getir_iptal_i    (getir_iptal_i),
        .getir_gecerli_o  (getir_gecerli_o),
        .getir_buyruk_o   (getir_buyruk_o),
        .temizle_i        (temizle_i),
        .bellek_istek_o   (bellek_istek_o),
        .bellek_adres_o   (bellek_adres_o),
        .bellek_hazir_i   (bellek_hazir_i),
        .bellek_gecerli_i (bellek_gecerli_i),
        .bellek_veri_i    (bellek_veri_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Single hit: response one cycle after the request edge.
    task automatic hit(input logic [31:0] adr, input logic [31:0] expected);
        getir_istek_i = 1'b1;
        getir_adres_i = adr;
        tick();
        getir_istek_i = 1'b0;
        chk("hit_valid", getir_gecerli_o, 1);
        chk("hit_data", getir_buyruk_o, expected);
        chk("hit_ready", getir_hazir_o, 1);
    endtask

    // Full miss with a scripted memory: waits before accept, gap between beats,
    // optional cancel / invalidate pulses on a given beat or at the request.
    task automatic miss(input logic [31:0] adr, input logic [31:0] base, input int waits,
                        input int gap, input int iptal_beat, input int temizle_beat,
                        input logic temizle_at_req, input logic exp_valid);
        logic [31:0] line;
        line = adr & 32'hFFFF_FFF0;
        getir_istek_i = 1'b1;
        getir_adres_i = adr;
        temizle_i     = temizle_at_req;
        tick();
        getir_istek_i = 1'b0;
        temizle_i     = 1'b0;
        chk("miss_req", bellek_istek_o, 1);
        chk("miss_addr", bellek_adres_o, line);
        chk("miss_ready", getir_hazir_o, 0);
        chk("miss_noresp", getir_gecerli_o, 0);
        for (int w = 0; w < waits; w++) begin
            tick();
            chk("wait_req", bellek_istek_o, 1);
            chk("wait_addr", bellek_adres_o, line);
        end
        bellek_hazir_i = 1'b1;
        tick();
        bellek_hazir_i = 1'b0;
        chk("req_drop", bellek_istek_o, 0);
        for (int b = 0; b < 4; b++) begin
            bellek_gecerli_i = 1'b1;
            bellek_veri_i    = base + 32'(b);
            getir_iptal_i    = (b == iptal_beat);
            temizle_i        = (b == temizle_beat);
            tick();
            bellek_gecerli_i = 1'b0;
            getir_iptal_i    = 1'b0;
            temizle_i        = 1'b0;
            if (b < 3) begin
                chk("fill_noresp", getir_gecerli_o, 0);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("gap_noresp", getir_gecerli_o, 0);
                end
            end
        end
        chk("resp_valid", getir_gecerli_o, 32'(exp_valid));
        if (exp_valid) chk("resp_data", getir_buyruk_o, base + 32'(adr[3:2]));
        chk("resp_notready", getir_hazir_o, 0);
        tick();
        chk("after_noresp", getir_gecerli_o, 0);
        chk("after_ready", getir_hazir_o, 1);
    endtask

    initial begin
        rst_i            = 1'b0;
        getir_istek_i    = 1'b0;
        getir_adres_i    = '0;
        getir_iptal_i    = 1'b0;
        temizle_i        = 1'b0;
        bellek_hazir_i   = 1'b0;
        bellek_gecerli_i = 1'b0;
        bellek_veri_i    = '0;
        tick();
        tick();
        chk("rst_ready", getir_hazir_o, 1);
        chk("rst_valid", getir_gecerli_o, 0);
        chk("rst_instr", getir_buyruk_o, 0);
        chk("rst_req", bellek_istek_o, 0);
        chk("rst_addr", bellek_adres_o, 0);
        #2 rst_i = 1'b1;
        tick();

        // Cold miss then hits in the same line, back to back.
        miss(32'h0000_0040, 32'hA0, 0, 0, -1, -1, 1'b0, 1'b1);
        hit(32'h0000_0044, 32'hA1);
        getir_istek_i = 1'b1;
        getir_adres_i = 32'h0000_0048;
        tick();
        chk("b2b_valid0", getir_gecerli_o, 1);
        chk("b2b_data0", getir_buyruk_o, 32'hA2);
        getir_adres_i = 32'h0000_004C;
        tick();
        getir_istek_i = 1'b0;
        chk("b2b_valid1", getir_gecerli_o, 1);
        chk("b2b_data1", getir_buyruk_o, 32'hA3);
        tick();
        chk("b2b_idle", getir_gecerli_o, 0);

        // Cancel in the hit cycle suppresses the response.
        getir_istek_i = 1'b1;
        getir_adres_i = 32'h0000_0044;
        getir_iptal_i = 1'b1;
        tick();
        getir_istek_i = 1'b0;
        getir_iptal_i = 1'b0;
        chk("hit_cancel", getir_gecerli_o, 0);
        chk("hit_cancel_req", bellek_istek_o, 0);

        // Conflict on index 4: tag 1 evicts tag 0, refetch of 0x40 misses.
        miss(32'h0000_0440, 32'hB0, 0, 0, -1, -1, 1'b0, 1'b1);
        hit(32'h0000_044C, 32'hB3);
        miss(32'h0000_0040, 32'hA0, 0, 0, -1, -1, 1'b0, 1'b1);

        // Memory wait states and beat gaps, response from word 2.
        miss(32'h0000_0108, 32'hC0, 3, 2, -1, -1, 1'b0, 1'b1);
        hit(32'h0000_0104, 32'hC1);

        // Cancel during refill: no response, but the line is valid afterwards.
        miss(32'h0000_0080, 32'hD0, 0, 0, 1, -1, 1'b0, 1'b0);
        hit(32'h0000_0080, 32'hD0);

        // Invalidate during refill: response delivered, line left invalid.
        miss(32'h0000_00C4, 32'hE0, 0, 0, -1, 2, 1'b0, 1'b1);
        miss(32'h0000_00C4, 32'hF0, 0, 0, -1, -1, 1'b0, 1'b1);
        hit(32'h0000_00C4, 32'hF1);
        // Invalidate in the same cycle as a would-be hit forces a miss.
        miss(32'h0000_00C4, 32'h50, 0, 0, -1, -1, 1'b1, 1'b1);

        // Reset in the middle of a burst.
        getir_istek_i = 1'b1;
        getir_adres_i = 32'h0000_0200;
        tick();
        getir_istek_i = 1'b0;
        chk("mid_req", bellek_istek_o, 1);
        bellek_hazir_i = 1'b1;
        tick();
        bellek_hazir_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bellek_gecerli_i = 1'b1;
            bellek_veri_i    = 32'h60 + 32'(b);
            tick();
        end
        bellek_gecerli_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        chk("mid_rst_ready", getir_hazir_o, 1);
        chk("mid_rst_valid", getir_gecerli_o, 0);
        chk("mid_rst_instr", getir_buyruk_o, 0);
        chk("mid_rst_req", bellek_istek_o, 0);
        chk("mid_rst_addr", bellek_adres_o, 0);
        tick();
        #2 rst_i = 1'b1;
        tick();
        for (int b = 2; b < 4; b++) begin
            bellek_gecerli_i = 1'b1;
            bellek_veri_i    = 32'h60 + 32'(b);
            tick();
            chk("late_beat_noresp", getir_gecerli_o, 0);
            chk("late_beat_ready", getir_hazir_o, 1);
        end
        bellek_gecerli_i = 1'b0;
        miss(32'h0000_0200, 32'h70, 0, 0, -1, -1, 1'b0, 1'b1);
        // Reset also dropped the earlier lines.
        miss(32'h0000_0080, 32'hD8, 0, 0, -1, -1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
